// File: rtl/sysx_slave_port.sv
// sysX slave port: decodes master word frames into an RX FIFO and serves MISO bytes from a TX FIFO.
// Optional SYSX_SLAVE_TXIRQ_EN: interrupt also asserts while the TX FIFO holds data.
module sysx_slave_port #(
  parameter logic [1:0]  pDeviceSelect  = 2'h1,
  parameter int unsigned pFifoDepthLog2 = 2,
  parameter logic [31:0] pIdleWord      = 32'hFFFF_FFFF
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iBusClock,
  input  logic [1:0]  iBusSelect,
  input  logic [7:0]  iBusMOSI,
  output logic [7:0]  oBusMISO,
  output logic        oBusInterrupt,
  output logic [31:0] oRxData,
  output logic        oRxValid,
  input  logic        iRxReady,
  input  logic [31:0] iTxData,
  input  logic        iTxValid,
  output logic        oTxReady,
  input  logic        iIntRequest,
  input  logic        iClearFlags,
  output logic        oOverflow,
  output logic        oUnderrun,
  output logic        oBusy
);

  localparam int unsigned FifoDepth = 1 << pFifoDepthLog2;
  localparam logic [pFifoDepthLog2:0] PtrOne = 1;

  typedef enum logic [1:0] {StIdle, StArmed, StFrame} state_t;
  state_t state, nextState;

  logic [1:0] busClkSync;
  logic       busClkPrev;
  logic [1:0] selSync0, selSync1;
  logic [7:0] mosiSync0, mosiSync1;
  logic [1:0] warmUp;
  logic       selected, busRise, busFall;

  logic [2:0]  phase;
  logic [1:0]  byteSel;
  logic        phaseIsData;
  logic [31:0] txShift, rxShift;
  logic        underrunPending;
  logic        frameRise, loadTx, wordDone;

  logic [31:0] rxMem [FifoDepth];
  logic [31:0] txMem [FifoDepth];
  logic [pFifoDepthLog2:0] rxWr, rxRd, txWr, txRd;
  logic rxEmpty, rxFull, txEmpty, txFull;
  logic rxPush, rxPop, txPush, txPop;
  logic overflowSet, underrunSet, intSource;

  // warmUp keeps IDLE from trusting the select synchroniser until it has refilled after reset
  always_ff @(posedge iClock) begin
    if (iReset) begin
      busClkSync <= '1;
      busClkPrev <= 1'b1;
      selSync0   <= '0;
      selSync1   <= '0;
      mosiSync0  <= '0;
      mosiSync1  <= '0;
      warmUp     <= '0;
    end else begin
      busClkSync <= {busClkSync[0], iBusClock};
      busClkPrev <= busClkSync[1];
      selSync0   <= iBusSelect;
      selSync1   <= selSync0;
      mosiSync0  <= iBusMOSI;
      mosiSync1  <= mosiSync0;
      warmUp     <= {warmUp[0], 1'b1};
    end
  end

  assign selected = (selSync1 == pDeviceSelect);
  assign busRise  = busClkSync[1] & ~busClkPrev;
  assign busFall  = ~busClkSync[1] & busClkPrev;

  always_ff @(posedge iClock) begin
    if (iReset) state <= StIdle;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      StIdle:  if (warmUp[1] && !selected) nextState = StArmed;
      StArmed: if (selected) nextState = StFrame;
      StFrame: if (!selected) nextState = StArmed;
      default: nextState = StIdle;
    endcase
  end

  assign phaseIsData = (phase >= 3'd1) && (phase <= 3'd4);
  assign byteSel     = phase[1:0] - 2'd1;

  always_comb begin
    oBusy    = 1'b0;
    oBusMISO = '0;
    if (state == StFrame) begin
      oBusy = 1'b1;
      if (phaseIsData) oBusMISO = txShift[{byteSel, 3'b000} +: 8];
    end
  end

  assign frameRise = (state == StFrame) && selected && busRise;
  assign loadTx    = ((state == StArmed) && selected) || (frameRise && (phase == 3'd5));
  assign wordDone  = frameRise && (phase == 3'd4);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      phase           <= '0;
      txShift         <= '0;
      rxShift         <= '0;
      underrunPending <= 1'b0;
    end else begin
      if ((state == StArmed) && selected) phase <= '0;
      else if (frameRise)                  phase <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
      if (loadTx) begin
        txShift         <= txEmpty ? pIdleWord : txMem[txRd[pFifoDepthLog2-1:0]];
        underrunPending <= txEmpty;
      end
      if ((state == StFrame) && selected && busFall && phaseIsData)
        rxShift[{byteSel, 3'b000} +: 8] <= mosiSync1;
    end
  end

  assign rxEmpty = (rxWr == rxRd);
  assign rxFull  = (rxWr[pFifoDepthLog2] != rxRd[pFifoDepthLog2]) &&
                   (rxWr[pFifoDepthLog2-1:0] == rxRd[pFifoDepthLog2-1:0]);
  assign txEmpty = (txWr == txRd);
  assign txFull  = (txWr[pFifoDepthLog2] != txRd[pFifoDepthLog2]) &&
                   (txWr[pFifoDepthLog2-1:0] == txRd[pFifoDepthLog2-1:0]);

  // A full RX FIFO still accepts the word when the head leaves in the same cycle
  assign rxPop  = iRxReady && !rxEmpty;
  assign rxPush = wordDone && (!rxFull || rxPop);
  assign txPush = iTxValid && !txFull;
  assign txPop  = wordDone && !underrunPending;

  assign overflowSet = wordDone && rxFull && !rxPop;
  assign underrunSet = wordDone && underrunPending;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      rxWr <= '0;
      rxRd <= '0;
      txWr <= '0;
      txRd <= '0;
    end else begin
      if (rxPush) rxWr <= rxWr + PtrOne;
      if (rxPop)  rxRd <= rxRd + PtrOne;
      if (txPush) txWr <= txWr + PtrOne;
      if (txPop)  txRd <= txRd + PtrOne;
    end
  end

  always_ff @(posedge iClock) begin
    if (rxPush) rxMem[rxWr[pFifoDepthLog2-1:0]] <= rxShift;
    if (txPush) txMem[txWr[pFifoDepthLog2-1:0]] <= iTxData;
  end

  assign oRxData  = rxMem[rxRd[pFifoDepthLog2-1:0]];
  assign oRxValid = !rxEmpty;
  assign oTxReady = !txFull;

`ifdef SYSX_SLAVE_TXIRQ_EN
  assign intSource = iIntRequest | !txEmpty;
`else
  assign intSource = iIntRequest;
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      oOverflow     <= 1'b0;
      oUnderrun     <= 1'b0;
      oBusInterrupt <= 1'b0;
    end else begin
      if (overflowSet)      oOverflow <= 1'b1;
      else if (iClearFlags) oOverflow <= 1'b0;
      if (underrunSet)      oUnderrun <= 1'b1;
      else if (iClearFlags) oUnderrun <= 1'b0;
      oBusInterrupt <= intSource;
    end
  end

endmodule
